// File: rtl/gb_video_pkg.sv
// Shared types and widths for the VRAM block-copy path.
package gb_video_pkg;

    localparam int SRC_AW  = 16;
    localparam int VRAM_AW = 8;
    localparam int DW      = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } dma_state_t;

    typedef struct packed {
        logic               en;
        logic [VRAM_AW-1:0] addr;
        logic [DW-1:0]      data;
    } vram_wr_t;

endpackage

// File: rtl/vram_wr_arbiter.sv
// VRAM write-port priority mux (CPU > hold > in-flight DMA byte) with a
// one-entry hold register that parks a DMA byte displaced by a CPU write.
module vram_wr_arbiter
    import gb_video_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               cpu_wr_en,
    input  logic [VRAM_AW-1:0] cpu_wr_addr,
    input  logic [DW-1:0]      cpu_wr_data,
    input  logic               pend,
    input  logic [DW-1:0]      mem_rd_data,
    input  logic [VRAM_AW-1:0] dst_ptr,
    output vram_wr_t           vram_wr,
    output logic               dma_wr,
    output logic               hold_v,
    output logic               hold_v_next
);

    logic               hold_v_reg;
    logic [VRAM_AW-1:0] hold_addr_reg;
    logic [DW-1:0]      hold_data_reg;

    assign hold_v = hold_v_reg;

    always_comb begin
        vram_wr     = '0;
        dma_wr      = 1'b0;
        hold_v_next = hold_v_reg;
        if (cpu_wr_en) begin
            vram_wr.en   = 1'b1;
            vram_wr.addr = cpu_wr_addr;
            vram_wr.data = cpu_wr_data;
            if (pend) begin
                hold_v_next = 1'b1;
            end
        end else if (hold_v_reg) begin
            vram_wr.en   = 1'b1;
            vram_wr.addr = hold_addr_reg;
            vram_wr.data = hold_data_reg;
            dma_wr       = 1'b1;
            hold_v_next  = 1'b0;
        end else if (pend) begin
            vram_wr.en   = 1'b1;
            vram_wr.addr = dst_ptr;
            vram_wr.data = mem_rd_data;
            dma_wr       = 1'b1;
        end
    end

    // Read data is only valid for one cycle, so a displaced byte must be captured now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v_reg    <= 1'b0;
            hold_addr_reg <= '0;
            hold_data_reg <= '0;
        end else begin
            hold_v_reg <= hold_v_next;
            if (cpu_wr_en && pend) begin
                hold_addr_reg <= dst_ptr;
                hold_data_reg <= mem_rd_data;
            end
        end
    end

endmodule

// File: rtl/vram_dma_engine.sv
// Block copy from system memory into VRAM, merged with direct CPU writes;
// new reads are paused while the renderer is active.
module vram_dma_engine
    import gb_video_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SRC_AW-1:0]  src_addr,
    input  logic [VRAM_AW-1:0] dst_addr,
    input  logic [VRAM_AW:0]   length,
    input  logic               render_active,
    input  logic               cpu_wr_en,
    input  logic [VRAM_AW-1:0] cpu_wr_addr,
    input  logic [DW-1:0]      cpu_wr_data,
    output logic               mem_rd_en,
    output logic [SRC_AW-1:0]  mem_rd_addr,
    input  logic [DW-1:0]      mem_rd_data,
    output logic               vram_wr_en,
    output logic [VRAM_AW-1:0] vram_wr_addr,
    output logic [DW-1:0]      vram_wr_data,
    output logic               busy,
    output logic               done
);

    dma_state_t         state_reg, state_next;
    logic [SRC_AW-1:0]  src_ptr_reg;
    logic [VRAM_AW-1:0] dst_ptr_reg;
    logic [VRAM_AW:0]   remaining_reg, remaining_next;
    logic               pend_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               issue;
    logic               dma_wr;
    logic               hold_v;
    logic               hold_v_next;
    vram_wr_t           vram_wr;

    vram_wr_arbiter u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_wr_addr (cpu_wr_addr),
        .cpu_wr_data (cpu_wr_data),
        .pend        (pend_reg),
        .mem_rd_data (mem_rd_data),
        .dst_ptr     (dst_ptr_reg),
        .vram_wr     (vram_wr),
        .dma_wr      (dma_wr),
        .hold_v      (hold_v),
        .hold_v_next (hold_v_next)
    );

    // A read blocked by a colliding CPU write keeps the single hold slot free.
    assign issue = (state_reg == RUN) && (remaining_reg != '0) && !render_active
                   && !hold_v && !(pend_reg && cpu_wr_en);
    assign remaining_next = issue ? remaining_reg - (VRAM_AW+1)'(1) : remaining_reg;

    // Transitions look at next-cycle counts so the final write overlaps DRAIN.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (remaining_next == '0) state_next = DRAIN;
            DRAIN:   if (!issue && !hold_v_next) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            src_ptr_reg   <= '0;
            dst_ptr_reg   <= '0;
            remaining_reg <= '0;
            pend_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == RUN) || (state_next == DRAIN);
            done_reg  <= (state_next == DONE);
            pend_reg  <= issue;
            if (state_reg == IDLE && start) begin
                src_ptr_reg   <= src_addr;
                dst_ptr_reg   <= dst_addr;
                remaining_reg <= length;
            end else begin
                remaining_reg <= remaining_next;
                if (issue) src_ptr_reg <= src_ptr_reg + SRC_AW'(1);
                if (dma_wr) dst_ptr_reg <= dst_ptr_reg + VRAM_AW'(1);
            end
        end
    end

    assign mem_rd_en    = issue;
    assign mem_rd_addr  = src_ptr_reg;
    assign vram_wr_en   = vram_wr.en;
    assign vram_wr_addr = vram_wr.addr;
    assign vram_wr_data = vram_wr.data;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule
